data_display: RTL
=================

# data_display

Reader end of the data generator's `RawData` bus. Continuously decodes the `Size`-bit word under the same `Signed`/`Code` interpretation the generator uses, and converts the magnitude to BCD with a sequential shift-add-3 engine. The result drives a time-multiplexed 7-segment display. The block sits on the board top next to the data generator and shares its clock.

## Interface
Parameters:
- `Size`, 5: width of `RawData`; 2..12.
- `Signed`, "No": "No" = unsigned; "Yes" = MSB is sign.
- `Code`, "Str": signed code, used only when `Signed`="Yes".
  - "Str": sign-magnitude.
  - "Inv": ones' complement.
  - "Add": two's complement.
- `Digits`, 4: digit count. Digit `Digits-1` is reserved for sign. Must satisfy `Digits-1` ≥ decimal digits of 2^`Size`-1.
- `ClockPeriod_ns`, 20: clock period.
- `ScanPeriod_ns`, 1_000_000: dwell time per digit. `ScanTicks` = `ScanPeriod_ns`/`ClockPeriod_ns`, minimum 2.

Ports:
- `Clock` in 1: system clock; all logic rising-edge.
- `Reset` in 1: synchronous, active-high.
- `RawData` in `Size`: word to display; synchronous to `Clock`.
- `Segments` out 8: active-low; [6:0] = g..a, [7] = dp. dp is always off (1).
- `DigitSel` out `Digits`: active-low one-hot digit enable.
- `Busy` out 1: high while a conversion is in flight.

## Operation
Decode, from `RawData` captured into `Cap`:
- Unsigned: `Neg`=0, `Mag`=`Cap`.
- "Str": `Neg`=MSB, `Mag`=low `Size-1` bits.
- "Inv": `Neg`=MSB, `Mag`=`Neg` ? ~low bits : low bits.
- "Add": `Neg`=MSB, `Mag`=`Neg` ? (−`Cap` mod 2^`Size`) : `Cap`.
- `Mag` is `Size` bits wide, so "Add" most-negative gives 2^(`Size`-1).
- Negative zero ("Str"/"Inv") displays as "-0".

Conversion FSM:
- IDLE: if `RawData` ≠ `Last` or `ReqAfterReset`:
  - capture `Cap`←`RawData` and `Last`←`RawData`;
  - clear `ReqAfterReset`;
  - → LOAD.
- LOAD: compute `Neg`/`Mag`, clear BCD shift register → SHIFT with bit counter = `Size`.
- SHIFT: one double-dabble step per cycle (add 3 to any BCD nibble ≥ 5, then shift in the `Mag` MSB). Counter decrements; at 1 → COMMIT.
- COMMIT: copy BCD and `Neg` into the display registers atomically → IDLE.
- `Busy` = state ≠ IDLE.
- `RawData` changes during a conversion are ignored until IDLE. The IDLE comparison then restarts, so the display always settles to the latest value.

Scan:
- Prescaler counts 0..`ScanTicks`-1. At wrap, the digit index advances `Digits-1`→…→0→`Digits-1` (wrap).
- Selected digit output mapping:
  - Digit `Digits-1`: minus (8'hBF) if `Neg`, else blank (8'hFF).
  - Other digits: BCD nibble encoded to 7-segment, subject to blanking (see Configuration).
- `Segments` and `DigitSel` are registered together, so the two never disagree for a cycle.

## Timing
- Reset:
  - `Segments`=8'hFF, `DigitSel`=all ones, `Busy`=0, state IDLE.
  - Display registers zero, prescaler 0, index `Digits-1`.
  - `ReqAfterReset`=1.
- Reset mid-conversion aborts it immediately; no partial commit.
- Latency: `RawData` change sampled at edge N; display registers updated at edge N+`Size`+2. `Busy` is high on cycles N+1..N+`Size`+2 and low after N+`Size`+2.
- First digit enable appears one cycle after `Reset` falls. `DigitSel` is all ones during reset only.
- A display register update takes effect on the digit currently scanned at the next clock; no blank gap.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: magnitude digits `Digits-2`..1 whose nibble and all higher nibbles are 0 show blank (8'hFF). Digit 0 is always shown.
  - Undefined: all magnitude digits show numerals, including leading zeros.
  - Sign digit behaviour is unchanged either way.

## Test plan
- Size=5, unsigned, `LEADING_ZERO_BLANK_EN` on, `RawData`=31 → scan shows blank,blank,3,1; `Busy` high exactly 7 cycles.
- Size=5, "Add", `RawData`=5'b10000 → digits "-",blank,1,6.
- Size=5, "Str", 5'b10011 → "-",blank,blank,3. "Inv", 5'b11100 → same. "Inv", 5'b11111 → "-",blank,blank,0.
- Blanking off, unsigned `RawData`=7 → blank,0,0,7.
- `RawData` 3→9 on the cycle after capture → display commits 3 at N+7, then 9 at N+7+8 (restart from IDLE); never shows another value.
- `Reset` asserted at SHIFT step 2 → next cycle all outputs at reset values. After release, reconversion of the current `RawData` commits `Size`+3 cycles later.

Source files
------------

// File: rtl/data_display.sv
// Reader for the generator's RawData bus: decodes the word, converts the magnitude to BCD by double-dabble
// and drives a multiplexed active-low 7-segment display. Optional macro: LEADING_ZERO_BLANK_EN.
module data_display #(
    parameter int    Size           = 5,
    parameter string Signed         = "No",
    parameter string Code           = "Str",
    parameter int    Digits         = 4,
    parameter int    ClockPeriod_ns = 20,
    parameter int    ScanPeriod_ns  = 1_000_000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [Size-1:0]   RawData,
    output logic [7:0]        Segments,
    output logic [Digits-1:0] DigitSel,
    output logic              Busy
);

    localparam bit IsSigned  = (Signed == "Yes");
    localparam bit CodeAdd   = (Code == "Add");
    localparam bit CodeInv   = (Code == "Inv");
    localparam int RawTicks  = ScanPeriod_ns / ClockPeriod_ns;
    localparam int ScanTicks = (RawTicks < 2) ? 2 : RawTicks;
    localparam int PW        = $clog2(ScanTicks);
    localparam int IW        = (Digits > 2) ? $clog2(Digits) : 1;
    localparam int NB        = 4 * (Digits - 1);
    localparam int CW        = $clog2(Size + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]        r_state;
    logic [Size-1:0]   r_cap;
    logic [Size-1:0]   r_last;
    logic              r_req;
    logic              r_neg;
    logic [Size-1:0]   r_mag;
    logic [NB-1:0]     r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [NB-1:0]     r_dispBcd;
    logic              r_dispNeg;
    logic [PW-1:0]     r_pre;
    logic [IW-1:0]     r_idx;
    logic [7:0]        r_seg;
    logic [Digits-1:0] r_sel;

    logic              w_neg;
    logic [Size-1:0]   w_mag;
    logic [NB-1:0]     w_bcdNext;
    logic [7:0]        w_seg;
    logic [Digits-1:0] w_sel;

    function automatic logic [7:0] f_sevenSeg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Mag stays Size bits wide so the two's-complement most-negative value keeps its full magnitude.
    always_comb begin
        w_neg = 1'b0;
        w_mag = r_cap;
        if (IsSigned) begin
            w_neg = r_cap[Size-1];
            if (CodeAdd) begin
                w_mag = w_neg ? (~r_cap + {{(Size-1){1'b0}}, 1'b1}) : r_cap;
            end else if (CodeInv) begin
                w_mag = {1'b0, (w_neg ? ~r_cap[Size-2:0] : r_cap[Size-2:0])};
            end else begin
                w_mag = {1'b0, r_cap[Size-2:0]};
            end
        end
    end

    always_comb begin
        w_bcdNext = r_bcd;
        for (int k = 0; k < Digits - 1; k++) begin
            if (w_bcdNext[4*k +: 4] >= 4'd5) begin
                w_bcdNext[4*k +: 4] = w_bcdNext[4*k +: 4] + 4'd3;
            end
        end
        w_bcdNext = {w_bcdNext[NB-2:0], r_mag[Size-1]};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b1;
            r_cap     <= '0;
            r_last    <= '0;
            r_neg     <= 1'b0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_dispBcd <= '0;
            r_dispNeg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if ((RawData != r_last) || r_req) begin
                        r_cap   <= RawData;
                        r_last  <= RawData;
                        r_req   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_neg   <= w_neg;
                    r_mag   <= w_mag;
                    r_bcd   <= '0;
                    r_cnt   <= CW'(Size);
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= w_bcdNext;
                    r_mag <= {r_mag[Size-2:0], 1'b0};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_COMMIT;
                    end
                end
                default: begin
                    r_dispBcd <= r_bcd;
                    r_dispNeg <= r_neg;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Scan walks from the sign digit down to digit 0, dwelling ScanTicks cycles on each.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pre <= '0;
            r_idx <= IW'(Digits - 1);
        end else if (r_pre == PW'(ScanTicks - 1)) begin
            r_pre <= '0;
            r_idx <= (r_idx == '0) ? IW'(Digits - 1) : (r_idx - IW'(1));
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    always_comb begin
        logic [3:0] nib;
`ifdef LEADING_ZERO_BLANK_EN
        logic       higherZero;
        higherZero = 1'b1;
`endif
        nib   = 4'd0;
        w_seg = 8'hFF;
        for (int k = Digits - 2; k >= 0; k--) begin
            nib = r_dispBcd[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            higherZero = higherZero && (nib == 4'd0);
            if (IW'(k) == r_idx) begin
                w_seg = (higherZero && (k != 0)) ? 8'hFF : f_sevenSeg(nib);
            end
`else
            if (IW'(k) == r_idx) begin
                w_seg = f_sevenSeg(nib);
            end
`endif
        end
        if (r_idx == IW'(Digits - 1)) begin
            w_seg = r_dispNeg ? 8'hBF : 8'hFF;
        end
    end

    always_comb begin
        w_sel = '1;
        for (int k = 0; k < Digits; k++) begin
            if (IW'(k) == r_idx) begin
                w_sel[k] = 1'b0;
            end
        end
    end

    // Segments and digit enable share one register stage so they always switch on the same edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_seg <= 8'hFF;
            r_sel <= '1;
        end else begin
            r_seg <= w_seg;
            r_sel <= w_sel;
        end
    end

    assign Segments = r_seg;
    assign DigitSel = r_sel;
    assign Busy     = (r_state != S_IDLE);

endmodule
